id_stage: RTL
=============

# id_stage

Decode stage of the 5-stage core. It holds the IF/ID pipeline register, the 32×32 register file, the main/ALU decoder, and branch/jump resolution. It also holds decode-side hazard detection (load-use and branch stalls) and the ID/EX pipeline register that drives the execute stage. It consumes `instnF`/`pcplus4F` from fetch and returns `pcsrcD`/`pcbranchD` to the PC generator.

## Interface
- `NOP_INSTN`, default 32'h0000_0000: value loaded into IF/ID on reset or flush. It decodes to all-zero controls.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `instnF`, `pcplus4F`  in  32 each  fetch-stage instruction and PC+4
- `pcsrcD`  out  1  1 = redirect the PC to `pcbranchD` (taken beq or j)
- `pcbranchD`  out  32  branch or jump target
- `stallF`  out  1  hold the PC register; equals `stallD`
- `regwriteW`  in  1  writeback enable
- `writeregW`  in  5  writeback register
- `resultW`  in  32  writeback data
- `regwriteM`, `memregM`  in  1 each  memory-stage controls
- `writeregM`  in  5  memory-stage destination
- `aluoutM`  in  32  memory-stage ALU result (branch forwarding)
- `regwriteE`, `memregE`, `memwriteE`, `alusrcE`, `regdstE`  out  1 each  ID/EX registered controls
- `aluctrlE`  out  3  ALU control: 000 and, 001 or, 010 add, 110 sub, 111 slt
- `AE`, `BE`, `signimmE`  out  32 each  registered rs data, rt data, and sign-extended immediate
- `rsE`, `rtE`, `rdE`  out  5 each  registered register specifiers

## Operation
- **Decode** (`instnD` fields `op[31:26]`, `funct[5:0]`):
  - R-type `op`=0: `regwrite`=1, `regdst`=1. Funct 20h→add, 22h→sub, 24h→and, 25h→or, 2Ah→slt. Any other funct gives all controls 0.
  - lw 23h: `regwrite`, `alusrc`, `memreg`, add.
  - sw 2Bh: `memwrite`, `alusrc`, add.
  - addi 08h: `regwrite`, `alusrc`, add.
  - beq 04h: `branch`.
  - j 02h: `jump`.
  - Any other opcode gives all controls 0.
- **Immediates:**
  - `signimmD` = sign-extend of `instnD[15:0]`.
  - Branch target = `pcplus4D + (signimmD<<2)`, with wrap-around on 32-bit overflow.
  - Jump target = `{pcplus4D[31:28], instnD[25:0], 2'b00}`.
  - `pcbranchD` = jump target when `jump`, else the branch target.
- **Register file:**
  - r0 reads 0 and ignores writes.
  - Written on the rising edge when `regwriteW` and `writeregW`≠0.
  - Same-cycle read of the register being written returns `resultW` (internal bypass).
  - All registers are cleared asynchronously by reset.
- **Branch compare:**
  - Operand A = `aluoutM` when `rsD`≠0, `rsD`==`writeregM` and `regwriteM`; else the register-file read.
  - Operand B is formed the same way using `rtD`.
  - `pcsrcD` = (`branch` & A==B) | `jump`.
- **Hazards:**
  - `writeregE` = `regdstE` ? `rdE` : `rtE`.
  - `lwstall` = `memregE` & (`rtE`==`rsD` | `rtE`==`rtD`).
  - `branchstall` = `branch` & ((`regwriteE` & `writeregE`≠0 & `writeregE`∈{`rsD`,`rtD`}) | (`memregM` & `writeregM`≠0 & `writeregM`∈{`rsD`,`rtD`})).
  - `stallD` = `stallF` = `lwstall` | `branchstall`.
  - `flushE` = `stallD`.
  - `pcsrcD` is forced to 0 while `stallD`=1.
- **IF/ID register:**
  - `stallD`: hold.
  - Else `pcsrcD`: load `NOP_INSTN` and `pcplus4D`=0, squashing the wrong-path fetch.
  - Else: load `instnF`/`pcplus4F`.
- **ID/EX register:**
  - `flushE`: all controls and specifiers become 0; data is don't-care but is zeroed.
  - Otherwise: load the decoded controls, read data, immediate, `rsD`/`rtD`/`rdD`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `instnD`=`NOP_INSTN`, `pcplus4D`=0.
  - All E outputs = 0.
  - All registers = 0.
  - Combinational outputs `pcsrcD`/`stallF` settle to 0.
- Reset mid-stall or mid-branch discards the in-flight instruction. No state survives reset.
- Decode-to-E latency: 1 cycle.
- Branch resolution: taken branch or jump in D redirects the PC on the same edge that flushes IF/ID. Penalty is 1 bubble; there is no delay slot.
- Load-use: exactly 1 stall cycle.
- Branch stalls:
  - Branch on an ALU result in E: 1 cycle.
  - Branch on a load result in E: 2 cycles.
  - Branch on a load result in M: 1 cycle.
- Simultaneous `stallD` and a taken branch: the stall wins, and the branch re-resolves next cycle.
- Write and read of the same register in one cycle: the reader sees the new value.

## Test plan
- Reset, then `addi $1,$0,5` (2001_0005) → next cycle: `regwriteE`=1, `alusrcE`=1, `aluctrlE`=010, `signimmE`=5, `rtE`=1, `pcsrcD`=0.
- `lw $2,0($1)` followed by `add $3,$2,$2` → `stallF`=`stallD`=1 for exactly one cycle. The ID/EX register gets a bubble (`regwriteE`=0). The add then issues with `rsE`=`rtE`=2.
- beq with equal operands, offset −1 → `pcsrcD`=1 and `pcbranchD`=`pcplus4D`−4. The following IF/ID value is `NOP_INSTN`.
- `writeregW`=5, `regwriteW`=1, `resultW`=DEAD_BEEF while D reads $5 → `AE`=DEAD_BEEF. A write to $0 leaves it reading 0.
- `j 0x0010_0000` with `pcplus4D`=0x4000_0004 → `pcbranchD`=0x4040_0000 and `pcsrcD`=1.
- Assert `rst_n` low mid-stall → all E outputs are 0 immediately and `stallF`=0.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage of the 5-stage core: IF/ID register, register file, decoder,
// branch/jump resolution, decode-side hazard detection and the ID/EX register.
module id_stage #(
  parameter logic [31:0] NOP_INSTN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instnF,
  input  logic [31:0] pcplus4F,
  output logic        pcsrcD,
  output logic [31:0] pcbranchD,
  output logic        stallF,
  input  logic        regwriteW,
  input  logic [4:0]  writeregW,
  input  logic [31:0] resultW,
  input  logic        regwriteM,
  input  logic        memregM,
  input  logic [4:0]  writeregM,
  input  logic [31:0] aluoutM,
  output logic        regwriteE,
  output logic        memregE,
  output logic        memwriteE,
  output logic        alusrcE,
  output logic        regdstE,
  output logic [2:0]  aluctrlE,
  output logic [31:0] AE,
  output logic [31:0] BE,
  output logic [31:0] signimmE,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [4:0]  rdE
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
    OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B
  } op_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A
  } funct_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_SLT = 3'b111
  } alu_e;

  typedef struct packed {
    logic       regwrite;
    logic       memreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       jump;
    logic [2:0] aluctrl;
  } ctrl_t;

  typedef struct packed {
    logic        regwrite;
    logic        memreg;
    logic        memwrite;
    logic        alusrc;
    logic        regdst;
    logic [2:0]  aluctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  logic [31:0] instn_d, pcplus4_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [31:0] signimm_d, rd1, rd2, cmp_a, cmp_b;
  logic [31:0] branch_target, jump_target;
  logic [4:0]  writereg_e;
  logic        lwstall, branchstall, stall_d;
  ctrl_t       ctrl;
  idex_t       ex_q;
  logic [31:0] rf [32];

  assign rs_d      = instn_d[25:21];
  assign rt_d      = instn_d[20:16];
  assign rd_d      = instn_d[15:11];
  assign signimm_d = {{16{instn_d[15]}}, instn_d[15:0]};

  // NOTE: every field gets a default before the case, so no path can infer a latch.
  always_comb begin
    ctrl = '0;
    case (instn_d[31:26])
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (instn_d[5:0])
          FN_ADD:  ctrl.aluctrl = ALU_ADD;
          FN_SUB:  ctrl.aluctrl = ALU_SUB;
          FN_AND:  ctrl.aluctrl = ALU_AND;
          FN_OR:   ctrl.aluctrl = ALU_OR;
          FN_SLT:  ctrl.aluctrl = ALU_SLT;
          default: ctrl = '0;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memreg   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
      end
      OP_BEQ:  ctrl.branch = 1'b1;
      OP_J:    ctrl.jump   = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // NOTE: the register file must clear on reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwriteW && writeregW != 5'd0) begin
      rf[writeregW] <= resultW;
    end
  end

  // Reads bypass the writeback port so a same-cycle write is visible.
  assign rd1 = (rs_d == 5'd0) ? '0 : (regwriteW && writeregW == rs_d) ? resultW : rf[rs_d];
  assign rd2 = (rt_d == 5'd0) ? '0 : (regwriteW && writeregW == rt_d) ? resultW : rf[rt_d];

  assign cmp_a = (rs_d != 5'd0 && rs_d == writeregM && regwriteM) ? aluoutM : rd1;
  assign cmp_b = (rt_d != 5'd0 && rt_d == writeregM && regwriteM) ? aluoutM : rd2;

  assign branch_target = pcplus4_d + {signimm_d[29:0], 2'b00};
  assign jump_target   = {pcplus4_d[31:28], instn_d[25:0], 2'b00};
  assign pcbranchD     = ctrl.jump ? jump_target : branch_target;

  assign writereg_e  = regdstE ? rdE : rtE;
  assign lwstall     = memregE && (rtE == rs_d || rtE == rt_d);
  assign branchstall = ctrl.branch &&
                       ((regwriteE && writereg_e != 5'd0 && (writereg_e == rs_d || writereg_e == rt_d)) ||
                        (memregM && writeregM != 5'd0 && (writeregM == rs_d || writeregM == rt_d)));
  assign stall_d     = lwstall || branchstall;
  assign stallF      = stall_d;

  // A stalled branch must not redirect; it re-resolves once its operands are ready.
  assign pcsrcD = !stall_d && ((ctrl.branch && cmp_a == cmp_b) || ctrl.jump);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instn_d   <= NOP_INSTN;
      pcplus4_d <= '0;
    end else if (!stall_d) begin
      if (pcsrcD) begin
        instn_d   <= NOP_INSTN;
        pcplus4_d <= '0;
      end else begin
        instn_d   <= instnF;
        pcplus4_d <= pcplus4F;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (stall_d) begin
      ex_q <= '0;
    end else begin
      ex_q.regwrite <= ctrl.regwrite;
      ex_q.memreg   <= ctrl.memreg;
      ex_q.memwrite <= ctrl.memwrite;
      ex_q.alusrc   <= ctrl.alusrc;
      ex_q.regdst   <= ctrl.regdst;
      ex_q.aluctrl  <= ctrl.aluctrl;
      ex_q.a        <= rd1;
      ex_q.b        <= rd2;
      ex_q.imm      <= signimm_d;
      ex_q.rs       <= rs_d;
      ex_q.rt       <= rt_d;
      ex_q.rd       <= rd_d;
    end
  end

  assign regwriteE = ex_q.regwrite;
  assign memregE   = ex_q.memreg;
  assign memwriteE = ex_q.memwrite;
  assign alusrcE   = ex_q.alusrc;
  assign regdstE   = ex_q.regdst;
  assign aluctrlE  = ex_q.aluctrl;
  assign AE        = ex_q.a;
  assign BE        = ex_q.b;
  assign signimmE  = ex_q.imm;
  assign rsE       = ex_q.rs;
  assign rtE       = ex_q.rt;
  assign rdE       = ex_q.rd;

endmodule
